// File: rtl/parking_pkg.sv
// Shared parking constants and types, also used by the capacity counter.
package parking_pkg;

    localparam int unsigned NUM_SPOTS       = 8;
    localparam int unsigned DEBOUNCE_CYCLES = 4;
    localparam int unsigned CNT_W           = 4;

    typedef logic [NUM_SPOTS-1:0] spot_vec_t;

    // Edges after reset release before occupancy is trustworthy: two
    // synchroniser stages plus one full debounce window.
    function automatic int unsigned settle_edges(input int unsigned debounce_cycles);
        return debounce_cycles + 2;
    endfunction

endpackage

// File: rtl/parking_spot_debounce.sv
// One spot: 2-flop synchroniser, debounce counter, committed level and
// registered arrive/depart pulses.
module parking_spot_debounce #(
    parameter int unsigned DebounceCycles = parking_pkg::DEBOUNCE_CYCLES,
    parameter int unsigned CntW           = parking_pkg::CNT_W
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sensor_i,
    output logic level_o,
    output logic arrive_o,
    output logic depart_o
);

    localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

    logic            sync1_q, sync2_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            arrive_q, arrive_d;
    logic            depart_q, depart_d;

    // Synchroniser: sensor is asynchronous to clk_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sensor_i;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: commit a new level only after it has held for DebounceCycles.
    always_comb begin
        cnt_d    = cnt_q;
        level_d  = level_q;
        arrive_d = 1'b0;
        depart_d = 1'b0;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntLast) begin
            level_d  = sync2_q;
            cnt_d    = '0;
            arrive_d = sync2_q;
            depart_d = ~sync2_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Debounce state and pulse registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            level_q  <= 1'b0;
            arrive_q <= 1'b0;
            depart_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            arrive_q <= arrive_d;
            depart_q <= depart_d;
        end
    end

    assign level_o  = level_q;
    assign arrive_o = arrive_q;
    assign depart_o = depart_q;

endmodule

// File: rtl/parking_spot_sensor_filter.sv
// Per-spot sensor synchronise/debounce array with event pulses and a
// post-reset validity flag feeding the capacity counter.
module parking_spot_sensor_filter #(
    parameter int unsigned NUM_SPOTS       = parking_pkg::NUM_SPOTS,
    parameter int unsigned DEBOUNCE_CYCLES = parking_pkg::DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = parking_pkg::CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_SPOTS-1:0] sensor_in,
    output logic [NUM_SPOTS-1:0] occupancy,
    output logic [NUM_SPOTS-1:0] arrive_pulse,
    output logic [NUM_SPOTS-1:0] depart_pulse,
    output logic                 change,
    output logic                 occupancy_valid
);

    import parking_pkg::*;

    localparam int unsigned SettleEdges = settle_edges(DEBOUNCE_CYCLES);
    localparam int unsigned VldW        = $clog2(SettleEdges + 1);
    localparam logic [VldW-1:0] VldLast = VldW'(SettleEdges - 1);

    logic [VldW-1:0] vld_cnt_q, vld_cnt_d;
    logic            valid_q, valid_d;

    for (genvar i = 0; i < NUM_SPOTS; i++) begin : g_spot
        parking_spot_debounce #(
            .DebounceCycles (DEBOUNCE_CYCLES),
            .CntW           (CNT_W)
        ) u_spot (
            .clk_i    (clk),
            .rst_ni   (rst_n),
            .sensor_i (sensor_in[i]),
            .level_o  (occupancy[i]),
            .arrive_o (arrive_pulse[i]),
            .depart_o (depart_pulse[i])
        );
    end

    // Pulses are already registered, so change is a plain OR in the same cycle.
    assign change = |(arrive_pulse | depart_pulse);

    // Settle timer: counts edges since release, then latches valid until reset.
    always_comb begin
        vld_cnt_d = vld_cnt_q;
        valid_d   = valid_q;
        if (!valid_q) begin
            vld_cnt_d = vld_cnt_q + 1'b1;
            if (vld_cnt_q == VldLast) begin
                valid_d = 1'b1;
            end
        end
    end

    // Settle timer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_cnt_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            vld_cnt_q <= vld_cnt_d;
            valid_q   <= valid_d;
        end
    end

    assign occupancy_valid = valid_q;

endmodule

// File: tb/tb_parking_spot_sensor_filter.sv
// Scoreboard bench: a sliding-window reference model pushes expected outputs
// per edge; a monitor pops and compares them one time unit after the edge.
module tb_parking_spot_sensor_filter;

    localparam int unsigned N = 8;
    localparam int unsigned D = 4;

    typedef struct packed {
        logic [N-1:0] occ;
        logic [N-1:0] arr;
        logic [N-1:0] dep;
        logic         chg;
        logic         vld;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] sensor_in;
    logic [N-1:0] occupancy, arrive_pulse, depart_pulse;
    logic         change, occupancy_valid;

    int n_cmp = 0;
    int n_bad = 0;

    exp_t         exp_q[$];
    logic [N-1:0] win[$];
    logic [N-1:0] m_occ, m_commit, m_new;
    int           m_edges;
    logic         m_all;
    exp_t         m_e;
    exp_t         got_e;

    parking_spot_sensor_filter #(
        .NUM_SPOTS       (N),
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sensor_in       (sensor_in),
        .occupancy       (occupancy),
        .arrive_pulse    (arrive_pulse),
        .depart_pulse    (depart_pulse),
        .change          (change),
        .occupancy_valid (occupancy_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [N-1:0] got, input logic [N-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
        end
    endtask

    // Reference model: a spot commits on an edge when every synchronised
    // sample in the last D-cycle window (raw samples n-2 .. n-1-D) differs
    // from its committed level.
    always @(posedge clk) begin
        if (!rst_n) begin
            win.delete();
            for (int k = 0; k < D + 1; k++) win.push_back('0);
            m_occ   = '0;
            m_edges = 0;
        end else begin
            win.push_front(sensor_in);
            for (int i = 0; i < N; i++) begin
                m_all = 1'b1;
                for (int k = 2; k < D + 2; k++) begin
                    if (win[k][i] == m_occ[i]) m_all = 1'b0;
                end
                m_commit[i] = m_all;
            end
            m_new   = m_occ ^ m_commit;
            m_edges = m_edges + 1;
            m_e.occ = m_new;
            m_e.arr = m_commit & m_new;
            m_e.dep = m_commit & ~m_new;
            m_e.chg = |m_commit;
            m_e.vld = (m_edges >= D + 2);
            m_occ   = m_new;
            void'(win.pop_back());
            exp_q.push_back(m_e);
        end
    end

    // Monitor: compare every post-edge output against the scoreboard.
    always begin
        @(posedge clk);
        #1;
        if (rst_n) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL scoreboard_empty at %0t: got no entry, expected one", $time);
            end else begin
                got_e = exp_q.pop_front();
                check("occupancy", occupancy, got_e.occ);
                check("arrive_pulse", arrive_pulse, got_e.arr);
                check("depart_pulse", depart_pulse, got_e.dep);
                check("change", {7'b0, change}, {7'b0, got_e.chg});
                check("occupancy_valid", {7'b0, occupancy_valid}, {7'b0, got_e.vld});
                check("pulse_exclusive", arrive_pulse & depart_pulse, '0);
            end
        end
    end

    task automatic hold(input logic [N-1:0] v, input int cycles);
        @(negedge clk);
        sensor_in = v;
        repeat (cycles - 1) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_occ"}, occupancy, '0);
        check({tag, "_arr"}, arrive_pulse, '0);
        check({tag, "_dep"}, depart_pulse, '0);
        check({tag, "_misc"}, {6'b0, change, occupancy_valid}, '0);
    endtask

    initial begin
        logic [N-1:0] r;
        rst_n     = 1'b0;
        sensor_in = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        hold(8'h00, 10);                 // idle; valid rises on edge 6
        hold(8'h01, 10);                 // single arrival
        hold(8'h09, 3);                  // 3-cycle glitch on spot 3
        hold(8'h01, 10);
        hold(8'h0F, 10);
        hold(8'hF0, 10);                 // simultaneous mixed events
        hold(8'hF1, 3);                  // interrupted debounce on spot 0
        hold(8'hF0, 1);
        hold(8'hF1, 10);
        hold(8'hFF, 10);

        // Asynchronous reset between edges clears outputs immediately.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        hold(8'hFF, 10);

        // Random stimulus: sparse per-bit toggles give both commits and glitches.
        r = 8'hFF;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 5) == 0) r[i] = ~r[i];
            end
            hold(r, 1);
            if (c == 700) begin
                #3;
                rst_n = 1'b0;
                #1;
                check_reset_outputs("rand_reset");
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        hold(r, 12);

        @(posedge clk);
        #2;
        check("scoreboard_drained", 8'(exp_q.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/parking_spot_sensor_filter.md
Name: parking_spot_sensor_filter

Overview:
- Upstream stage of the parking capacity counter.
- Takes raw, asynchronous, bouncy per-spot occupancy sensors and synchronises and debounces each one.
- Registers the result as a clean 8-bit occupancy vector, bit i = 1 meaning spot i is occupied, which drives the counter's capacity input directly.
- Also emits one-cycle arrival/departure event pulses and a validity flag for downstream display/gate logic.

Parameters:
- NUM_SPOTS, 8, number of parking spots; width of sensor and occupancy vectors.
- DEBOUNCE_CYCLES, 4, consecutive synchronised cycles a new sensor level must hold before it is committed (legal 2..15).
- CNT_W, 4, width of per-spot debounce counter; must hold DEBOUNCE_CYCLES-1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- sensor_in  input  NUM_SPOTS  raw spot sensors, asynchronous to clk, 1 = car present.
- occupancy  output  NUM_SPOTS  debounced registered occupancy vector, feeds capacity counter.
- arrive_pulse  output  NUM_SPOTS  bit i high one cycle when spot i commits 0->1.
- depart_pulse  output  NUM_SPOTS  bit i high one cycle when spot i commits 1->0.
- change  output  1  OR of all arrive_pulse and depart_pulse bits, same cycle.
- occupancy_valid  output  1  low after reset until the first full settle window has elapsed.

Behaviour:
- Reset (rst_n low, asynchronous): sync flops, debounce counters, occupancy, arrive_pulse, depart_pulse, change, occupancy_valid all 0.
- Reset asserted mid-debounce discards the partial count. Spots come out of reset reading empty.
- Per spot, synchronisation: 2-flop synchroniser; sync2 is the synchronised level.
- Per spot, debounce, evaluated each rising edge:
  - sync2 == occupancy[i]: counter <= 0.
  - sync2 != occupancy[i] and counter < DEBOUNCE_CYCLES-1: counter increments.
  - sync2 != occupancy[i] and counter == DEBOUNCE_CYCLES-1: occupancy[i] <= sync2, counter <= 0, and the matching pulse bit is set for exactly the next cycle.
- Latency: a sensor level held stable from before edge 1 is committed on rising edge 2+DEBOUNCE_CYCLES (edge 6 at default).
- Glitch rejection: any synchronised excursion shorter than DEBOUNCE_CYCLES cycles leaves occupancy unchanged and returns the counter to 0.
- Counter restart: the counter restarts from 0 whenever sync2 returns to the committed level; counts never accumulate across interruptions.
- Independence and simultaneous events: spots are independent. Several spots may commit on the same edge, giving multiple pulse bits set together and change = 1 once. Arrival on one spot and departure on another in the same cycle are both reported.
- Pulse exclusivity: arrive_pulse[i] and depart_pulse[i] are never high together; pulses are registered and default to 0 each cycle.
- occupancy_valid:
  - A saturating counter starts at reset release.
  - Goes 1 on edge 2+DEBOUNCE_CYCLES after rst_n deasserts and stays 1 until the next reset.
  - occupancy is driven regardless of occupancy_valid.
- Arithmetic: counters are unsigned CNT_W bits and never wrap, because they clear at DEBOUNCE_CYCLES-1.

Decomposition:
- Shared package parking_pkg:
  - constants NUM_SPOTS = 8 and DEBOUNCE_CYCLES = 4, shared with the capacity counter, whose 4-bit count width also comes from here;
  - typedef spot_vec_t = logic [NUM_SPOTS-1:0].
- Sub-module parking_spot_debounce: one spot, holding the synchroniser, counter, committed level and arrive/depart pulse.
- The top instantiates NUM_SPOTS copies via generate and adds the change OR and the occupancy_valid timer.

Test Plan:
- Reset then idle: rst_n low 3 cycles, sensor_in = 8'h00, release -> all outputs 0. occupancy_valid rises on edge 6 after release.
- Single arrival: sensor_in 8'h00 -> 8'h01 held -> occupancy = 8'h01 on edge 6; arrive_pulse = 8'h01 and change = 1 for exactly one cycle; then 0.
- Glitch rejection: sensor_in[3] high 3 cycles then low -> occupancy stays 8'h00; no pulses; change stays 0.
- Simultaneous mixed events: occupancy = 8'h0F settled, then sensor_in -> 8'hF0 -> on one edge occupancy = 8'hF0, arrive_pulse = 8'hF0, depart_pulse = 8'h0F, change = 1 for one cycle.
- Interrupted debounce: sensor_in[0] 0->1 for 3 cycles, back to 0 one cycle, then 1 held -> commit occurs 2+4 edges after the final rise, not earlier.
- Reset mid-operation: occupancy = 8'hFF, sensor_in 8'hFF, assert rst_n between clock edges -> occupancy = 8'h00 immediately. After release, occupancy returns to 8'hFF on edge 6 with arrive_pulse = 8'hFF.
